bod_adc_frontend: RTL
=====================

# bod_adc_frontend

Sampling front-end for the brownout path. It drives a 20-bit serial ADC (CNV/SCK/SDO, MSB first) at a fixed sample period and assembles each conversion into a 20-bit word. It also produces the two hysteretic supply-level flags: warning and critical. Its outputs feed the rate/brownout decision logic directly, which samples them on the falling edge of `clk`.

## Interface
Parameters:
- `ADC_WIDTH`, 20: conversion word width. Fixed for this design.
- `CLK_DIV`, 2: `clk` cycles per SCK half-period. Must be ≥1.
- `CONV_CYCLES`, 8: `clk` cycles that CNV is held high per conversion. Must be ≥1.
- `SAMPLE_PERIOD`, 200: `clk` cycles between consecutive CNV rising edges.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock. All state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: sampling enable. Sampled only in IDLE.
- `warn_level` in 20: warning threshold, in ADC codes.
- `crit_level` in 20: critical threshold, in ADC codes.
- `hyst` in 12: release hysteresis, in ADC codes. Shared by both flags.
- `adc_sdo` in 1: serial data from the ADC.
- `adc_cnv` out 1: conversion start to the ADC.
- `adc_sck` out 1: serial clock to the ADC. Idles low.
- `adc_out` out 20: last completed sample.
- `sample_valid` out 1: one-cycle pulse when `adc_out`, `bod_out1` and `bod_out2` update.
- `bod_out1` out 1: warning flag. Supply is below `warn_level`.
- `bod_out2` out 1: critical flag. Supply is below `crit_level`.

## Operation
- FSM states: IDLE → CONVERT → SHIFT → UPDATE → IDLE.
- IDLE
  - Go to CONVERT when `en`=1 and the period counter has reached `SAMPLE_PERIOD`-1.
  - The counter saturates rather than wraps.
  - With `en`=0, stay in IDLE; all outputs hold.
- CONVERT
  - `adc_cnv`=1 for exactly `CONV_CYCLES` cycles.
  - The period counter restarts at 0 in the first CONVERT cycle.
- SHIFT
  - `adc_cnv`=0.
  - `adc_sck` toggles every `CLK_DIV` cycles, starting low: 20 full pulses, 40·`CLK_DIV` cycles total.
  - `adc_sdo` is captured into the shift register in the cycle `adc_sck` goes 0→1, MSB first.
  - After the 20th falling edge, go to UPDATE.
- UPDATE (one cycle)
  - `adc_out` ← assembled word; `sample_valid`=1.
  - Both flags are recomputed from the new word.
  - Threshold and `hyst` inputs are used as sampled in this cycle. Changes during CONVERT/SHIFT have no effect until then.
- Flag rule, identical for flag n with level L:
  - Set when sample < L.
  - Clear when sample ≥ L + `hyst`.
  - Otherwise hold.
  - L + `hyst` is computed 21 bits wide and saturates to 20'hFFFFF. A flag with L + `hyst` > 20'hFFFFF therefore clears only at 20'hFFFFF.
  - `hyst`=0 gives a plain comparator.
- The two flags are independent. `crit_level` > `warn_level` is legal: `bod_out2` may then assert without `bod_out1`.
- `en` deasserted mid-frame does not abort the frame. The current frame completes through UPDATE, then the FSM stays in IDLE.

## Timing
- Reset values: `adc_cnv`=0, `adc_sck`=0, `adc_out`=0, `sample_valid`=0, `bod_out1`=0, `bod_out2`=0. FSM is in IDLE, period counter saturated.
- First conversion: the first cycle after `rst` falls with `en`=1 enters CONVERT.
- Latency: if `adc_cnv` rises in cycle t, `sample_valid`=1 in cycle t + `CONV_CYCLES` + 40·`CLK_DIV`. With defaults that is t+88.
- Period: CNV rising edges are `SAMPLE_PERIOD` cycles apart.
  - If `SAMPLE_PERIOD` < `CONV_CYCLES` + 40·`CLK_DIV` + 2, frames run back-to-back with one IDLE cycle between UPDATE and the next CONVERT.
- Every output is registered on the rising edge. All outputs are therefore stable across the falling edge at which the consumer samples them.
- `rst` asserted mid-frame: the next edge returns every output to its reset value and the FSM to IDLE. The partial word is discarded.

## Structure
- Package `bod_pkg`:
  - `ADC_WIDTH`=20;
  - the FSM state enum `bod_fe_state_t` (IDLE, CONVERT, SHIFT, UPDATE);
  - a saturating threshold-plus-hysteresis function.
- Sub-module `bod_hyst_cmp` (sample, level, hyst, update strobe → flag register), instantiated twice, once per flag.
- The top level holds the FSM, the SCK divider, the bit counter (0–19), the period counter and the shift register.

## Test plan
- Reset/idle
  - Stimulus: hold `rst`=1 for 5 cycles, `en`=0 for 300 cycles.
  - Required: all outputs stay 0; no CNV or SCK activity.
- Single capture
  - Stimulus: ADC model returns 20'hA5C3F; defaults.
  - Required: `adc_cnv` high for 8 cycles; 20 SCK pulses of 4 cycles each; `sample_valid` at t+88 with `adc_out`=20'hA5C3F.
- Hysteresis
  - Stimulus: `warn_level`=20'h80000, `hyst`=16; samples 20'h7FFFF, 20'h80008, 20'h80010.
  - Required: `bod_out1`=1, 1, 0 in order.
- Critical and saturation
  - Stimulus: `crit_level`=20'hFFFF0, `hyst`=12'hFFF; samples 20'h00001, then 20'hFFFFE, then 20'hFFFFF.
  - Required: `bod_out2`=1, 1, 0.
- Period
  - Stimulus: `SAMPLE_PERIOD`=200, then a rebuild with `SAMPLE_PERIOD`=50.
  - Required: CNV rising edges 200 apart; with 50, they are 90 apart (back-to-back frames).
- Mid-frame events
  - `rst` pulsed during SHIFT bit 10: outputs clear, the partial word is never published, and a new frame starts the cycle after `rst` falls.
  - `en` dropped during SHIFT: that frame still completes with `sample_valid`=1, and no further CNV follows.

Source files
------------

// File: rtl/bod_pkg.sv
// Shared types and helpers for the brownout ADC sampling front-end.
package bod_pkg;

  localparam int ADC_WIDTH  = 20;
  localparam int HYST_WIDTH = 12;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    SHIFT,
    UPDATE
  } bod_fe_state_t;

  // Release threshold level + hyst, clamped to full scale instead of wrapping.
  function automatic logic [ADC_WIDTH-1:0] sat_release(
    input logic [ADC_WIDTH-1:0]  level,
    input logic [HYST_WIDTH-1:0] hyst
  );
    logic [ADC_WIDTH:0] sum;
    sum = {1'b0, level} + {{(ADC_WIDTH + 1 - HYST_WIDTH){1'b0}}, hyst};
    return sum[ADC_WIDTH] ? {ADC_WIDTH{1'b1}} : sum[ADC_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/bod_hyst_cmp.sv
// Hysteretic supply-level flag: sets below level, clears at or above the
// saturated release level, otherwise holds. Only changes on the update strobe.
module bod_hyst_cmp
  import bod_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  update,
  input  logic [ADC_WIDTH-1:0]  sample,
  input  logic [ADC_WIDTH-1:0]  level,
  input  logic [HYST_WIDTH-1:0] hyst,
  output logic                  flag
);

  logic [ADC_WIDTH-1:0] clear_level;

  assign clear_level = sat_release(level, hyst);

  always_ff @(posedge clk) begin
    if (rst) begin
      flag <= 1'b0;
    end else if (update) begin
      if (sample < level) begin
        flag <= 1'b1;
      end else if (sample >= clear_level) begin
        flag <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/bod_adc_frontend.sv
// Serial ADC sampling front-end: paced CNV/SCK generation, MSB-first word
// assembly and the warning/critical hysteretic flags.
module bod_adc_frontend #(
  parameter int ADC_WIDTH     = bod_pkg::ADC_WIDTH,
  parameter int CLK_DIV       = 2,
  parameter int CONV_CYCLES   = 8,
  parameter int SAMPLE_PERIOD = 200
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic [ADC_WIDTH-1:0]           warn_level,
  input  logic [ADC_WIDTH-1:0]           crit_level,
  input  logic [bod_pkg::HYST_WIDTH-1:0] hyst,
  input  logic                           adc_sdo,
  output logic                           adc_cnv,
  output logic                           adc_sck,
  output logic [ADC_WIDTH-1:0]           adc_out,
  output logic                           sample_valid,
  output logic                           bod_out1,
  output logic                           bod_out2
);

  import bod_pkg::*;

  localparam int PW = $clog2(SAMPLE_PERIOD + 1);
  localparam int CW = $clog2(CONV_CYCLES + 1);
  localparam int DW = $clog2(CLK_DIV + 1);

  localparam logic [PW-1:0] PERIOD_MAX = PW'(SAMPLE_PERIOD - 1);
  localparam logic [CW-1:0] CONV_LAST  = CW'(CONV_CYCLES - 1);
  localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
  localparam logic [4:0]    BIT_LAST   = 5'(ADC_WIDTH - 1);

  bod_fe_state_t        state;
  logic [PW-1:0]        period_cnt;
  logic [CW-1:0]        conv_cnt;
  logic [DW-1:0]        div_cnt;
  logic [4:0]           bit_cnt;
  logic [ADC_WIDTH-1:0] shift_reg;
  logic                 frame_done;

  // The last SCK falling edge of a frame; the word is complete in shift_reg.
  assign frame_done = (state == SHIFT) && (div_cnt == DIV_LAST) && adc_sck &&
                      (bit_cnt == BIT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      period_cnt   <= PERIOD_MAX;
      conv_cnt     <= '0;
      div_cnt      <= '0;
      bit_cnt      <= '0;
      shift_reg    <= '0;
      adc_cnv      <= 1'b0;
      adc_sck      <= 1'b0;
      adc_out      <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (period_cnt != PERIOD_MAX) begin
        period_cnt <= period_cnt + PW'(1);
      end

      unique case (state)
        IDLE: begin
          if (en && (period_cnt == PERIOD_MAX)) begin
            state      <= CONVERT;
            adc_cnv    <= 1'b1;
            conv_cnt   <= '0;
            period_cnt <= '0;
          end
        end

        CONVERT: begin
          if (conv_cnt == CONV_LAST) begin
            state   <= SHIFT;
            adc_cnv <= 1'b0;
            adc_sck <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
          end else begin
            conv_cnt <= conv_cnt + CW'(1);
          end
        end

        // SCK rising edge captures SDO; falling edge advances the bit count.
        SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            adc_sck <= ~adc_sck;
            if (!adc_sck) begin
              shift_reg <= {shift_reg[ADC_WIDTH-2:0], adc_sdo};
            end else if (frame_done) begin
              state        <= UPDATE;
              adc_out      <= shift_reg;
              sample_valid <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end

        UPDATE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  bod_hyst_cmp u_warn_cmp (
    .clk    (clk),
    .rst    (rst),
    .update (frame_done),
    .sample (shift_reg),
    .level  (warn_level),
    .hyst   (hyst),
    .flag   (bod_out1)
  );

  bod_hyst_cmp u_crit_cmp (
    .clk    (clk),
    .rst    (rst),
    .update (frame_done),
    .sample (shift_reg),
    .level  (crit_level),
    .hyst   (hyst),
    .flag   (bod_out2)
  );

endmodule
